exm_lane_join: RTL and testbench

Parametrised completion join between the N execute/memory lanes and writeback. Each lane reports when its result is ready: ALU results are ready at once, while dcache, div and mul results take several cycles. The block holds early results, waits until every valid lane is done, then loads the whole bundle into one output register for WB, with ws_ready backpressure and flush. It replaces the fixed two-lane my_ok/another_ok handshake with an N-lane, arbitrary-payload version and adds a join-stall performance counter.

---
 rtl/exm_join_pkg.sv | 24 ++
 rtl/exm_join_lane.sv | 77 +++++++
 rtl/exm_lane_join.sv | 99 +++++++++
 tb/tb_exm_lane_join.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exm_join_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exm_join_pkg
// Description : Shared lane-state encoding and default payload width for the
//               EXM-to-WB completion join.
// Revision    : 1.0
// ============================================================================
package exm_join_pkg;

    localparam logic [1:0] LS_IDLE = 2'b00;
    localparam logic [1:0] LS_WAIT = 2'b01;
    localparam logic [1:0] LS_HELD = 2'b10;

    // Matches the ES_TO_WS bus width carried into writeback.
    localparam int ES_TO_WS_BUS_WD = 102;

    typedef enum logic [1:0] {
        ST_IDLE = LS_IDLE,
        ST_WAIT = LS_WAIT,
        ST_HELD = LS_HELD
    } lane_state_e;

endpackage
`default_nettype wire

// File: rtl/exm_join_lane.sv
`default_nettype none
// ============================================================================
// Module      : exm_join_lane
// Description : One lane of the completion join: tracks the lane's progress
//               and holds an early result until the whole bundle can leave.
// Revision    : 1.0
// ============================================================================
module exm_join_lane
    import exm_join_pkg::*;
#(
    parameter int BUS_WD = ES_TO_WS_BUS_WD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_fire,
    input  logic              i_valid,
    input  logic              i_done,
    input  logic [BUS_WD-1:0] i_bus,
    output logic              o_ok,
    output logic              o_held,
    output logic [BUS_WD-1:0] o_bus
);

    lane_state_e       r_state;
    lane_state_e       w_state_nxt;
    logic              w_capture;
    logic [BUS_WD-1:0] r_hold;

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        if (i_fire) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid && i_done) begin
                        w_state_nxt = ST_HELD;
                        w_capture   = 1'b1;
                    end else if (i_valid) begin
                        w_state_nxt = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_valid && i_done) begin
                        w_state_nxt = ST_HELD;
                        w_capture   = 1'b1;
                    end else if (!i_valid) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_HELD: w_state_nxt = ST_HELD;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_hold <= i_bus;
            end
        end
    end

    // Once held, the lane no longer depends on the live done/payload inputs.
    assign o_held = (r_state == ST_HELD);
    assign o_ok   = ~i_valid | o_held | i_done;
    assign o_bus  = o_held ? r_hold : i_bus;

endmodule
`default_nettype wire

// File: rtl/exm_lane_join.sv
`default_nettype none
// ============================================================================
// Module      : exm_lane_join
// Description : N-lane completion join between EXM and WB with a registered
//               output bundle, backpressure, flush and a join-stall counter.
// Revision    : 1.0
// ============================================================================
module exm_lane_join
    import exm_join_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int BUS_WD = ES_TO_WS_BUS_WD,
    parameter int CNT_WD = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [LANES-1:0]        in_valid,
    input  logic [LANES-1:0]        in_done,
    input  logic [LANES*BUS_WD-1:0] in_bus,
    input  logic                    ws_ready,
    output logic                    es_ready,
    output logic [LANES-1:0]        lane_ok,
    output logic                    out_valid,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*BUS_WD-1:0] out_bus,
    output logic [CNT_WD-1:0]       stall_cnt
);

    logic [LANES-1:0]        w_held;
    logic [LANES*BUS_WD-1:0] w_sel_bus;
    logic                    w_any_valid;
    logic                    w_join;
    logic                    w_fire;
    logic                    w_stall;

    logic                    r_out_valid;
    logic [LANES-1:0]        r_out_lane_valid;
    logic [LANES*BUS_WD-1:0] r_out_bus;
    logic [CNT_WD-1:0]       r_stall_cnt;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            exm_join_lane #(
                .BUS_WD (BUS_WD)
            ) u_lane (
                .clk     (clk),
                .rst     (reset),
                .i_flush (flush),
                .i_fire  (w_fire),
                .i_valid (in_valid[gi]),
                .i_done  (in_done[gi]),
                .i_bus   (in_bus[gi*BUS_WD +: BUS_WD]),
                .o_ok    (lane_ok[gi]),
                .o_held  (w_held[gi]),
                .o_bus   (w_sel_bus[gi*BUS_WD +: BUS_WD])
            );
        end
    endgenerate

    assign w_any_valid = |in_valid;
    assign w_join      = (&lane_ok) & w_any_valid;
    assign w_fire      = w_join & (~r_out_valid | ws_ready) & ~flush & ~reset;
    assign w_stall     = w_any_valid & ~w_fire & ~flush;
    assign es_ready    = w_fire | ~w_any_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_out_valid      <= 1'b0;
            r_out_lane_valid <= '0;
            r_out_bus        <= '0;
        end else if (w_fire) begin
            r_out_valid      <= 1'b1;
            r_out_lane_valid <= in_valid;
            r_out_bus        <= w_sel_bus;
        end else if (ws_ready) begin
            r_out_valid      <= 1'b0;
        end
    end

    // Flush does not clear the counter; it only suppresses counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_lane_valid = r_out_lane_valid;
    assign out_bus        = r_out_bus;
    assign stall_cnt      = r_stall_cnt;

    logic w_unused;
    assign w_unused = ^w_held;

endmodule
`default_nettype wire

// File: tb/tb_exm_lane_join.sv
`default_nettype none
// ============================================================================
// Module      : tb_exm_lane_join
// Description : Directed scenarios plus randomized bundles checked through a
//               scoreboard against a transaction-level model of the join.
// Revision    : 1.0
// ============================================================================
module tb_exm_lane_join;

    localparam int LANES  = 2;
    localparam int BUS_WD = 16;
    localparam int CNT_WD = 4;
    localparam int LW     = LANES * BUS_WD;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic [LANES-1:0]  in_valid;
    logic [LANES-1:0]  in_done;
    logic [LW-1:0]     in_bus;
    logic              ws_ready;
    logic              es_ready;
    logic [LANES-1:0]  lane_ok;
    logic              out_valid;
    logic [LANES-1:0]  out_lane_valid;
    logic [LW-1:0]     out_bus;
    logic [CNT_WD-1:0] stall_cnt;

    exm_lane_join #(
        .LANES  (LANES),
        .BUS_WD (BUS_WD),
        .CNT_WD (CNT_WD)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_done        (in_done),
        .in_bus         (in_bus),
        .ws_ready       (ws_ready),
        .es_ready       (es_ready),
        .lane_ok        (lane_ok),
        .out_valid      (out_valid),
        .out_lane_valid (out_lane_valid),
        .out_bus        (out_bus),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [LANES-1:0] lv;
        logic [LW-1:0]    bus;
    } bundle_t;

    bundle_t exp_q[$];
    bit      mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid = '0;
        in_done  = '0;
        in_bus   = '0;
        flush    = 1'b0;
    endtask

    // Scoreboard monitor: a bundle is consumed whenever WB accepts a valid output.
    always @(negedge clk) begin
        if (mon_en && out_valid && ws_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bundle", {31'd0, out_valid}, 64'd0);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                chk("bundle_lane_valid", 64'(out_lane_valid), 64'(e.lv));
                chk("bundle_bus", 64'(out_bus), 64'(e.bus));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LANES-1:0]  mask;
        logic [BUS_WD-1:0] pay [LANES];
        int                d   [LANES];
        int                maxd;
        int                c;
        int                est;
        bit                occ;
        bit                mfire;
        bit                fin;
        bundle_t           eb;

        reset = 1'b1; ws_ready = 1'b1; idle_in();
        step(); step();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_lane_valid", 64'(out_lane_valid), 64'd0);
        chk("rst_out_bus", 64'(out_bus), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        chk("rst_es_ready", 64'(es_ready), 64'd1);
        chk("rst_lane_ok", 64'(lane_ok), 64'h3);
        step();

        // Both lanes done together
        in_valid = 2'b11; in_done = 2'b11; in_bus = {16'h000B, 16'h000A};
        @(negedge clk);
        chk("both_es_ready", 64'(es_ready), 64'd1);
        step(); idle_in();
        @(negedge clk);
        chk("both_out_valid", 64'(out_valid), 64'd1);
        chk("both_out_bus", 64'(out_bus), 64'h000B000A);
        chk("both_stall", 64'(stall_cnt), 64'd0);
        step();

        // Staggered completion: lane0 early, lane1 three cycles later
        in_valid = 2'b11; in_done = 2'b01; in_bus = {16'h0022, 16'h0011};
        @(negedge clk);
        chk("stag_es_ready_c1", 64'(es_ready), 64'd0);
        chk("stag_lane_ok_c1", 64'(lane_ok), 64'h1);
        step();
        in_done = 2'b00; in_bus = {16'h0022, 16'h0099};
        @(negedge clk);
        chk("stag_lane_ok_held", 64'(lane_ok), 64'h1);
        step(); step();
        in_done = 2'b10;
        @(negedge clk);
        chk("stag_es_ready_c4", 64'(es_ready), 64'd1);
        step(); idle_in();
        @(negedge clk);
        chk("stag_out_bus", 64'(out_bus), 64'h00220011);
        chk("stag_stall", 64'(stall_cnt), 64'd3);
        step();

        // Output full under backpressure
        ws_ready = 1'b0;
        in_valid = 2'b11; in_done = 2'b11; in_bus = {16'h0102, 16'h0304};
        @(negedge clk);
        chk("full_first_fire", 64'(es_ready), 64'd1);
        step();
        in_bus = {16'h0055, 16'h0066};
        @(negedge clk);
        chk("full_es_ready_c1", 64'(es_ready), 64'd0);
        step();
        in_done = 2'b00; in_bus = {16'hEEEE, 16'hEEEE};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_es_ready_wait", 64'(es_ready), 64'd0);
            chk("full_lane_ok_held", 64'(lane_ok), 64'h3);
            step();
        end
        ws_ready = 1'b1;
        @(negedge clk);
        chk("full_es_ready_c4", 64'(es_ready), 64'd1);
        chk("full_old_bundle", 64'(out_bus), 64'h01020304);
        step(); idle_in();
        @(negedge clk);
        chk("full_new_valid", 64'(out_valid), 64'd1);
        chk("full_new_bundle", 64'(out_bus), 64'h00550066);
        chk("full_stall", 64'(stall_cnt), 64'd6);
        ws_ready = 1'b0;
        step();

        // Flush collides with join
        in_valid = 2'b11; in_done = 2'b11; in_bus = {16'h0077, 16'h0078}; flush = 1'b1;
        @(negedge clk);
        chk("flush_out_valid_before", 64'(out_valid), 64'd1);
        chk("flush_es_ready", 64'(es_ready), 64'd0);
        step();
        flush = 1'b0; in_done = 2'b00;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_bus", 64'(out_bus), 64'd0);
        chk("flush_lanes_idle", 64'(lane_ok), 64'h0);
        step();
        ws_ready = 1'b1; in_done = 2'b11; in_bus = {16'h0033, 16'h0044};
        @(negedge clk);
        chk("post_flush_es_ready", 64'(es_ready), 64'd1);
        step(); idle_in();
        @(negedge clk);
        chk("post_flush_bundle", 64'(out_bus), 64'h00330044);
        chk("post_flush_stall", 64'(stall_cnt), 64'd7);
        ws_ready = 1'b0;
        step();

        // Reset while lane1 waits and the output is occupied
        in_valid = 2'b11; in_done = 2'b01; in_bus = {16'h0005, 16'h0006};
        step();
        in_done = 2'b00;
        @(negedge clk);
        chk("rstmid_lane_ok", 64'(lane_ok), 64'h1);
        chk("rstmid_out_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_out_valid_after", 64'(out_valid), 64'd0);
        chk("rstmid_stall", 64'(stall_cnt), 64'd0);
        chk("rstmid_lanes_idle", 64'(lane_ok), 64'h0);
        step();

        // Permanent stall saturates the counter
        repeat (22) step();
        @(negedge clk);
        chk("stall_saturate", 64'(stall_cnt), 64'd15);
        step();

        // Randomized bundles against the transaction model
        idle_in(); ws_ready = 1'b1; reset = 1'b1;
        step();
        reset = 1'b0;
        occ = 1'b0; est = 0;
        mon_en = 1'b1;
        for (int b = 0; b < 80; b++) begin
            repeat ($urandom_range(0, 2)) begin
                idle_in();
                ws_ready = ($urandom_range(0, 1) == 1);
                @(negedge clk);
                chk("rand_es_ready_idle", 64'(es_ready), 64'd1);
                if (ws_ready) occ = 1'b0;
                step();
            end
            mask = LANES'($urandom_range(1, (1 << LANES) - 1));
            maxd = 0;
            eb.lv  = mask;
            eb.bus = '0;
            for (int i = 0; i < LANES; i++) begin
                pay[i] = BUS_WD'($urandom);
                d[i]   = $urandom_range(0, 4);
                if (mask[i]) begin
                    eb.bus[i*BUS_WD +: BUS_WD] = pay[i];
                    if (d[i] > maxd) maxd = d[i];
                end
            end
            exp_q.push_back(eb);
            c = 0; fin = 1'b0;
            while (!fin) begin
                in_valid = mask;
                for (int i = 0; i < LANES; i++) begin
                    if (mask[i]) begin
                        in_done[i] = (c == d[i]);
                        in_bus[i*BUS_WD +: BUS_WD] = (c <= d[i]) ? pay[i] : BUS_WD'($urandom);
                    end else begin
                        in_done[i] = ($urandom_range(0, 1) == 1);
                        in_bus[i*BUS_WD +: BUS_WD] = '0;
                    end
                end
                ws_ready = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                mfire = (c >= maxd) && (!occ || ws_ready);
                chk("rand_es_ready", 64'(es_ready), 64'(mfire));
                chk("rand_stall", 64'(stall_cnt), 64'(est));
                if (!mfire && est < 15) est++;
                occ = mfire ? 1'b1 : (ws_ready ? 1'b0 : occ);
                if (es_ready) fin = 1'b1;
                step();
                c++;
                if (!fin && c > 200) begin
                    chk("rand_timeout", 64'(c), 64'd0);
                    fin = 1'b1;
                end
            end
        end
        idle_in(); ws_ready = 1'b1;
        repeat (3) step();
        mon_en = 1'b0;
        @(negedge clk);
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_out_drained", 64'(out_valid), 64'd0);
        chk("rand_final_stall", 64'(stall_cnt), 64'(est));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
